// File: rtl/alu_exec_unit_if.sv
// Request/response bus of the ALU execution unit.
// The request side and the result side each use a valid/ready handshake.
interface alu_exec_unit_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   opcode;
    logic [5:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic [2:0]   alu_op;
    logic         illegal;

    modport master (
        output in_valid, opcode, func, a, b, out_ready,
        input  in_ready, out_valid, result, zero, alu_op, illegal
    );

    modport slave (
        input  in_valid, opcode, func, a, b, out_ready,
        output in_ready, out_valid, result, zero, alu_op, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution unit: one-cycle ADD/SUB/AND/OR/SLT and a
// W-cycle shift-add multiplier, with a result register held until consumed.
module alu_exec_unit #(
    parameter int W      = 32,
    parameter int MUL_EN = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    localparam int CW = $clog2(W);

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [W-1:0]  acc;
    logic [W-1:0]  result_reg;
    logic [2:0]    alu_op_reg;
    logic          illegal_reg;
    logic          zero_reg;
    logic          out_valid_reg;

    logic [2:0]    sel;
    logic [2:0]    dec_op;
    logic          dec_mul;
    logic          dec_illegal;
    logic [W-1:0]  dec_result;
    logic [W-1:0]  acc_next;
    logic          in_ready;
    logic          accept;

    // Decode: the function field selects the operation only when the low
    // opcode bits are zero; the MUL encoding overrides the table.
    always_comb begin
        sel         = (bus.opcode[2:0] == 3'b000) ? bus.func[2:0] : bus.opcode[2:0];
        dec_mul     = (MUL_EN != 0) && (bus.opcode == 6'b000000) && (bus.func == 6'b011000);
        dec_illegal = 1'b0;
        dec_op      = OP_NONE;
        if (dec_mul) begin
            dec_op = OP_MUL;
        end else begin
            case (sel)
                3'b001:                 dec_op = OP_ADD;
                3'b010, 3'b101, 3'b110: dec_op = OP_SUB;
                3'b011:                 dec_op = OP_AND;
                3'b100:                 dec_op = OP_OR;
                3'b111:                 dec_op = OP_SLT;
                default: begin
                    dec_op      = OP_NONE;
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        dec_result = '0;
        case (dec_op)
            OP_ADD:  dec_result = bus.a + bus.b;
            OP_SUB:  dec_result = bus.a - bus.b;
            OP_AND:  dec_result = bus.a & bus.b;
            OP_OR:   dec_result = bus.a | bus.b;
            OP_SLT:  dec_result = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: dec_result = '0;
        endcase
    end

    // One multiplier bit per cycle; the multiplicand walks left as the
    // multiplier walks right, so only the low W product bits are kept.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Held low in reset so no request can be taken while the unit is cleared.
    assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            result_reg    <= '0;
            alu_op_reg    <= OP_NONE;
            illegal_reg   <= 1'b0;
            zero_reg      <= 1'b1;
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            if (dec_mul) begin
                state         <= MUL;
                count         <= '0;
                mcand         <= bus.a;
                mplier        <= bus.b;
                acc           <= '0;
                out_valid_reg <= 1'b0;
            end else begin
                state         <= DONE;
                result_reg    <= dec_result;
                alu_op_reg    <= dec_op;
                illegal_reg   <= dec_illegal;
                zero_reg      <= (dec_result == '0);
                out_valid_reg <= 1'b1;
            end
        end else begin
            case (state)
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(W - 1)) begin
                        state         <= DONE;
                        result_reg    <= acc_next;
                        alu_op_reg    <= OP_MUL;
                        illegal_reg   <= 1'b0;
                        zero_reg      <= (acc_next == '0);
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.alu_op    = alu_op_reg;
    assign bus.illegal   = illegal_reg;
endmodule
